// File: rtl/div_sqrt_sequencer_pkg.sv
// Shared types and constants for the divide/sqrt request sequencer.
// The optional watchdog is enabled by defining DIV_SQRT_TIMEOUT_EN.
package div_sqrt_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_e;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [2:0] RM_NEAR_EVEN   = 3'd0;
    localparam logic [2:0] RM_MINMAG      = 3'd1;
    localparam logic [2:0] RM_MIN         = 3'd2;
    localparam logic [2:0] RM_MAX         = 3'd3;
    localparam logic [2:0] RM_NEAR_MAXMAG = 3'd4;
    localparam logic [2:0] RM_ODD         = 3'd6;

    function automatic logic [4:0] flag_mask(input int pos);
        return 5'b00001 << pos;
    endfunction

endpackage

// File: rtl/div_sqrt_resp_buf.sv
// One-entry result holding register presenting a valid/ready response.
// clear drops a held entry immediately and wins over a simultaneous load.
module div_sqrt_resp_buf
    import div_sqrt_sequencer_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [W-1:0]     load_out,
    input  logic [4:0]       load_flags,
    input  logic [TAG_W-1:0] load_tag,
    input  logic             load_sqrt,
    input  logic             load_timeout,
    input  logic             clear,
    input  logic             resp_ready,
    output logic             resp_valid,
    output logic [W-1:0]     resp_out,
    output logic [4:0]       resp_flags,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_sqrt,
    output logic             resp_timeout
);

    logic             valid_r;
    logic [W-1:0]     out_r;
    logic [4:0]       flags_r;
    logic [TAG_W-1:0] tag_r;
    logic             sqrt_r;
    logic             timeout_r;

    // Occupancy flag: set on load, dropped on handshake or clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
        end else if (clear) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
        end else if (valid_r && resp_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Payload register, held stable while the entry waits for the consumer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_r     <= {W{1'b0}};
            flags_r   <= 5'b00000;
            tag_r     <= {TAG_W{1'b0}};
            sqrt_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else if (load && !clear) begin
            out_r     <= load_out;
            flags_r   <= load_flags;
            tag_r     <= load_tag;
            sqrt_r    <= load_sqrt;
            timeout_r <= load_timeout;
        end else begin
            out_r     <= out_r;
            flags_r   <= flags_r;
            tag_r     <= tag_r;
            sqrt_r    <= sqrt_r;
            timeout_r <= timeout_r;
        end
    end

    assign resp_valid   = valid_r;
    assign resp_out     = out_r;
    assign resp_flags   = flags_r;
    assign resp_tag     = tag_r;
    assign resp_sqrt    = sqrt_r;
    assign resp_timeout = timeout_r;

endmodule

// File: rtl/div_sqrt_sequencer.sv
// Single-outstanding sequencer between a request pipe and a divide/sqrt unit.
// Define DIV_SQRT_TIMEOUT_EN to add a WAIT watchdog and the resp_timeout port.
module div_sqrt_sequencer
    import div_sqrt_sequencer_pkg::*;
#(
    parameter int expWidth = 8,
    parameter int sigWidth = 24,
    parameter int TAG_W    = 5,
    parameter int TIMEOUT  = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_sqrt,
    input  logic [2:0]                   req_rm,
    input  logic [TAG_W-1:0]             req_tag,
    input  logic [expWidth+sigWidth-1:0] req_a,
    input  logic [expWidth+sigWidth-1:0] req_b,
    input  logic                         flush,
    output logic                         du_inValid,
    input  logic                         du_inReady,
    output logic                         du_sqrtOp,
    output logic [expWidth+sigWidth-1:0] du_a,
    output logic [expWidth+sigWidth-1:0] du_b,
    output logic [2:0]                   du_roundingMode,
    input  logic                         du_outValid,
    input  logic [expWidth+sigWidth-1:0] du_out,
    input  logic [4:0]                   du_exceptionFlags,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [expWidth+sigWidth-1:0] resp_out,
    output logic [4:0]                   resp_flags,
    output logic [TAG_W-1:0]             resp_tag,
`ifdef DIV_SQRT_TIMEOUT_EN
    output logic                         resp_timeout,
`endif
    output logic                         resp_sqrt
);

    localparam int W = expWidth + sigWidth;

    seq_state_e       state_r;
    seq_state_e       next_state_s;
    logic             op_sqrt_r;
    logic [2:0]       op_rm_r;
    logic [TAG_W-1:0] op_tag_r;
    logic [W-1:0]     op_a_r;
    logic [W-1:0]     op_b_r;
    logic             drop_r;
    logic             accept_s;
    logic             wdog_expire_s;
    logic             result_load_s;
    logic             timeout_load_s;
    logic [W-1:0]     load_out_s;
    logic [4:0]       load_flags_s;
    logic             buf_timeout_s;

`ifdef DIV_SQRT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wdog_cnt_r;

    // Watchdog: counts consecutive WAIT cycles, restarts on every WAIT entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_WAIT) && (next_state_s == ST_WAIT)) begin
            wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
        end else begin
            wdog_cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign wdog_expire_s = (state_r == ST_WAIT) && (wdog_cnt_r == WDOG_LAST);
    assign resp_timeout  = buf_timeout_s;
`else
    logic unused_timeout_param;
    logic unused_resp_timeout;

    assign wdog_expire_s        = 1'b0;
    assign unused_timeout_param = (TIMEOUT == 32'sd0);
    assign unused_resp_timeout  = buf_timeout_s;
`endif

    assign accept_s       = (state_r == ST_IDLE) && req_valid && !flush;
    // A real strobe wins over a watchdog expiry landing in the same cycle.
    assign result_load_s  = (state_r == ST_WAIT) && du_outValid && !flush && !drop_r;
    assign timeout_load_s = (state_r == ST_WAIT) && !du_outValid && wdog_expire_s
                            && !flush && !drop_r;
    assign load_out_s     = timeout_load_s ? {W{1'b0}} : du_out;
    assign load_flags_s   = timeout_load_s ? flag_mask(FLAG_NV) : du_exceptionFlags;

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; flush always returns to IDLE except from WAIT.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    next_state_s = ST_IDLE;
                end else if (du_inReady) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (du_outValid || wdog_expire_s) begin
                    next_state_s = (flush || drop_r) ? ST_IDLE : ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (flush || resp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs, forced low while reset is asserted.
    always_comb begin
        req_ready  = 1'b0;
        du_inValid = 1'b0;
        if (reset) begin
            req_ready  = 1'b0;
            du_inValid = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_ready = 1'b1;
                end
                ST_ISSUE: begin
                    du_inValid = 1'b1;
                end
                default: begin
                    req_ready  = 1'b0;
                    du_inValid = 1'b0;
                end
            endcase
        end
    end

    // Operand capture on request acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_sqrt_r <= 1'b0;
            op_rm_r   <= 3'd0;
            op_tag_r  <= {TAG_W{1'b0}};
            op_a_r    <= {W{1'b0}};
            op_b_r    <= {W{1'b0}};
        end else if (accept_s) begin
            op_sqrt_r <= req_sqrt;
            op_rm_r   <= req_rm;
            op_tag_r  <= req_tag;
            op_a_r    <= req_a;
            op_b_r    <= req_b;
        end else begin
            op_sqrt_r <= op_sqrt_r;
            op_rm_r   <= op_rm_r;
            op_tag_r  <= op_tag_r;
            op_a_r    <= op_a_r;
            op_b_r    <= op_b_r;
        end
    end

    // Drop flag: remembers a flush seen in WAIT until the unit answers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_r <= 1'b0;
        end else if ((state_r != ST_WAIT) || (next_state_s != ST_WAIT)) begin
            drop_r <= 1'b0;
        end else if (flush) begin
            drop_r <= 1'b1;
        end else begin
            drop_r <= drop_r;
        end
    end

    assign du_sqrtOp       = op_sqrt_r;
    assign du_a            = op_a_r;
    assign du_b            = op_b_r;
    assign du_roundingMode = op_rm_r;

    div_sqrt_resp_buf #(
        .W     (W),
        .TAG_W (TAG_W)
    ) u_resp_buf (
        .clock        (clock),
        .reset        (reset),
        .load         (result_load_s || timeout_load_s),
        .load_out     (load_out_s),
        .load_flags   (load_flags_s),
        .load_tag     (op_tag_r),
        .load_sqrt    (op_sqrt_r),
        .load_timeout (timeout_load_s),
        .clear        (flush),
        .resp_ready   (resp_ready),
        .resp_valid   (resp_valid),
        .resp_out     (resp_out),
        .resp_flags   (resp_flags),
        .resp_tag     (resp_tag),
        .resp_sqrt    (resp_sqrt),
        .resp_timeout (buf_timeout_s)
    );

endmodule

// File: tb/tb_div_sqrt_sequencer.sv
// Scoreboard bench for div_sqrt_sequencer: stimulus pushes expected issues and
// responses, negedge monitors pop and compare on each DUT handshake.
module tb_div_sqrt_sequencer;

    localparam int W  = 32;
    localparam int TW = 5;
`ifdef DIV_SQRT_TIMEOUT_EN
    localparam int DIR_LAT = 6;
`else
    localparam int DIR_LAT = 10;
`endif

    typedef struct packed {
        logic [W-1:0]  out;
        logic [4:0]    flags;
        logic [TW-1:0] tag;
        logic          sqrt;
        logic          to;
    } resp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sqrt;
        logic [2:0]   rm;
    } iss_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_sqrt = 1'b0;
    logic [2:0]    req_rm = 3'd0;
    logic [TW-1:0] req_tag = '0;
    logic [W-1:0]  req_a = '0;
    logic [W-1:0]  req_b = '0;
    logic          flush = 1'b0;
    logic          du_inValid;
    logic          du_inReady = 1'b0;
    logic          du_sqrtOp;
    logic [W-1:0]  du_a;
    logic [W-1:0]  du_b;
    logic [2:0]    du_roundingMode;
    logic          du_outValid = 1'b0;
    logic [W-1:0]  du_out = '0;
    logic [4:0]    du_exceptionFlags = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [W-1:0]  resp_out;
    logic [4:0]    resp_flags;
    logic [TW-1:0] resp_tag;
    logic          resp_sqrt;
    logic          dut_timeout;

    resp_t resp_q[$];
    iss_t  iss_q[$];
    resp_t mon_r;
    iss_t  mon_i;
    int    checks = 0;
    int    errors = 0;

    always #5 clock = ~clock;

    div_sqrt_sequencer #(
        .expWidth (8),
        .sigWidth (24),
        .TAG_W    (TW),
        .TIMEOUT  (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_sqrt          (req_sqrt),
        .req_rm            (req_rm),
        .req_tag           (req_tag),
        .req_a             (req_a),
        .req_b             (req_b),
        .flush             (flush),
        .du_inValid        (du_inValid),
        .du_inReady        (du_inReady),
        .du_sqrtOp         (du_sqrtOp),
        .du_a              (du_a),
        .du_b              (du_b),
        .du_roundingMode   (du_roundingMode),
        .du_outValid       (du_outValid),
        .du_out            (du_out),
        .du_exceptionFlags (du_exceptionFlags),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_out          (resp_out),
        .resp_flags        (resp_flags),
        .resp_tag          (resp_tag),
`ifdef DIV_SQRT_TIMEOUT_EN
        .resp_timeout      (dut_timeout),
`endif
        .resp_sqrt         (resp_sqrt)
    );

`ifndef DIV_SQRT_TIMEOUT_EN
    assign dut_timeout = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitors: every handshake the DUT performs must match the scoreboard head.
    always @(negedge clock) begin
        if (!reset && resp_valid && resp_ready) begin
            if (resp_q.size() == 0) begin
                chk("resp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_r = resp_q.pop_front();
                chk("resp_out", resp_out, mon_r.out);
                chk("resp_flags", resp_flags, mon_r.flags);
                chk("resp_tag", resp_tag, mon_r.tag);
                chk("resp_sqrt", resp_sqrt, mon_r.sqrt);
`ifdef DIV_SQRT_TIMEOUT_EN
                chk("resp_timeout", dut_timeout, mon_r.to);
`endif
            end
        end
        if (!reset && du_inValid && du_inReady) begin
            if (iss_q.size() == 0) begin
                chk("issue_unexpected", 64'd1, 64'd0);
            end else begin
                mon_i = iss_q.pop_front();
                chk("issue_a", du_a, mon_i.a);
                chk("issue_b", du_b, mon_i.b);
                chk("issue_sqrt", du_sqrtOp, mon_i.sqrt);
                chk("issue_rm", du_roundingMode, mon_i.rm);
            end
        end
    end

    // mode: 0 normal, 1 flush in ISSUE, 2 flush in WAIT, 3 flush with strobe, 4 flush in RESP
    task automatic do_op(input int mode, input int rdly, input int lat, input int rsdly,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic sq,
                         input logic [2:0] rm, input logic [TW-1:0] tag,
                         input logic [W-1:0] res, input logic [4:0] fl);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_a = a; req_b = b; req_sqrt = sq; req_rm = rm; req_tag = tag;
        tick();
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_sqrt = ~sq;
        req_rm = 3'($urandom); req_tag = TW'($urandom);
        if (mode != 1) iss_q.push_back(iss_t'{a, b, sq, rm});
        for (int i = 0; i < rdly; i++) begin
            chk("issue_hold_valid", du_inValid, 1);
            chk("issue_hold_a", du_a, a);
            chk("issue_hold_b", du_b, b);
            tick();
        end
        if (mode == 1) begin
            chk("issue_before_flush", du_inValid, 1);
            flush = 1'b1;
            tick();
            flush = 1'b0;
            chk("flush_issue_valid", du_inValid, 0);
            chk("flush_issue_ready", req_ready, 1);
            return;
        end
        du_inReady = 1'b1;
        tick();
        du_inReady = 1'b0;
        chk("wait_no_inValid", du_inValid, 0);
        if (mode == 2 && lat == 0) lat = 1;
        for (int i = 0; i < lat; i++) begin
            flush = (mode == 2) && (i == ((lat > 1) ? 1 : 0));
            tick();
        end
        flush = (mode == 3);
        du_outValid = 1'b1; du_out = res; du_exceptionFlags = fl;
        if (mode == 0) resp_q.push_back(resp_t'{res, fl, tag, sq, 1'b0});
        tick();
        du_outValid = 1'b0; flush = 1'b0; du_out = $urandom; du_exceptionFlags = 5'($urandom);
        if (mode == 2 || mode == 3) begin
            chk("drop_no_resp", resp_valid, 0);
            chk("drop_ready", req_ready, 1);
            return;
        end
        chk("resp_latency", resp_valid, 1);
        for (int i = 0; i < rsdly; i++) begin
            du_outValid = 1'($urandom_range(0, 1));
            du_out = $urandom;
            tick();
            du_outValid = 1'b0;
            chk("resp_hold_valid", resp_valid, 1);
            chk("resp_hold_out", resp_out, res);
            chk("resp_hold_flags", resp_flags, fl);
            chk("resp_hold_noaccept", req_ready, 0);
        end
        if (mode == 4) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            chk("flush_resp_valid", resp_valid, 0);
            chk("flush_resp_ready", req_ready, 1);
            return;
        end
        chk("resp_done_noaccept", req_ready, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("post_resp_valid", resp_valid, 0);
        chk("post_resp_ready", req_ready, 1);
    endtask

    initial begin
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_du_inValid", du_inValid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rel_req_ready", req_ready, 1);
        chk("rel_resp_out", resp_out, 0);

        do_op(0, 0, DIR_LAT, 0, 32'h40400000, 32'h3F800000, 1'b0, 3'd0, 5'd3,
              32'h40400000, 5'b00000);
        do_op(0, 4, 3, 0, $urandom, $urandom, 1'b1, 3'd2, 5'd7, $urandom, 5'b00001);
        do_op(2, 0, 5, 0, $urandom, $urandom, 1'b0, 3'd1, 5'd9, $urandom, 5'b00000);
        do_op(0, 0, 2, 6, $urandom, $urandom, 1'b0, 3'd4, 5'd21, $urandom, 5'b01000);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                du_outValid = 1'b1; du_out = $urandom;
                tick();
                du_outValid = 1'b0;
                chk("idle_stray", resp_valid, 0);
            end
            do_op(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                  $urandom, $urandom, 1'($urandom), 3'($urandom_range(0, 4)),
                  TW'($urandom), $urandom, 5'($urandom));
        end

        // Reset in WAIT abandons the operation.
        req_valid = 1'b1; req_a = 32'h12345678; req_b = 32'h9abcdef0; req_sqrt = 1'b0;
        req_rm = 3'd0; req_tag = 5'd11;
        tick();
        req_valid = 1'b0;
        iss_q.push_back(iss_t'{32'h12345678, 32'h9abcdef0, 1'b0, 3'd0});
        du_inReady = 1'b1;
        tick();
        du_inReady = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_du_inValid", du_inValid, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("postrst_du_a", du_a, 0);
        chk("postrst_du_b", du_b, 0);
        chk("postrst_resp_out", resp_out, 0);
        chk("postrst_resp_tag", resp_tag, 0);
        chk("postrst_req_ready", req_ready, 1);
        du_outValid = 1'b1; du_out = 32'hdeadbeef;
        tick();
        du_outValid = 1'b0;
        chk("postrst_late_strobe", resp_valid, 0);
        chk("postrst_still_idle", req_ready, 1);

`ifdef DIV_SQRT_TIMEOUT_EN
        begin
            int n;
            req_valid = 1'b1; req_a = 32'h3f800000; req_b = 32'h0; req_sqrt = 1'b1;
            req_rm = 3'd3; req_tag = 5'd30;
            tick();
            req_valid = 1'b0;
            iss_q.push_back(iss_t'{32'h3f800000, 32'h0, 1'b1, 3'd3});
            du_inReady = 1'b1;
            tick();
            du_inReady = 1'b0;
            n = 0;
            while (!resp_valid && n < 40) begin
                tick();
                n++;
            end
            chk("tmo_cycles", n, 8);
            resp_q.push_back(resp_t'{32'h0, 5'b10000, 5'd30, 1'b1, 1'b1});
            du_outValid = 1'b1; du_out = 32'h55555555; du_exceptionFlags = 5'b00001;
            tick();
            du_outValid = 1'b0;
            chk("tmo_late_out", resp_out, 0);
            chk("tmo_late_flags", resp_flags, 5'b10000);
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            chk("tmo_done", resp_valid, 0);
        end
`endif

        tick();
        tick();
        chk("resp_q_drained", resp_q.size(), 0);
        chk("iss_q_drained", iss_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
